// File: rtl/img_conv_seq.sv
// Command sequencer for the image-convolution SoC: decodes host opcodes, holds geometry/sigma/pass
// registers and launches the RX, TX and row-convolution controllers through start/busy handshakes.
module img_conv_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DIM_W   = 8,
    parameter int unsigned SIGMA_W = 3,
    parameter int unsigned PASS_W  = 3,
    parameter int unsigned WDOG_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         op,
    input  logic [DATA_W-1:0]  din,
    input  logic               abort,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               err,
    output logic [DIM_W-1:0]   nrows,
    output logic [DIM_W-1:0]   ncols,
    output logic               rx_start,
    output logic               tx_start,
    output logic               conv_start,
    input  logic               rx_busy,
    input  logic               tx_busy,
    input  logic               conv_busy,
    output logic               sub_abort,
    output logic [DIM_W-1:0]   conv_nrows,
    output logic [DIM_W-1:0]   conv_ncols,
    output logic [SIGMA_W-1:0] conv_sigma,
    output logic [1:0]         img_sel,
    output logic               buf_sel,
    output logic               swap
);
    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StGap} state_e;

    localparam logic [3:0] OpGetNrows = 4'd1, OpGetNcols = 4'd2, OpGetSigma = 4'd3;
    localparam logic [3:0] OpSetNrows = 4'd4, OpSetNcols = 4'd5, OpSetSigma = 4'd6;
    localparam logic [3:0] OpImgRx = 4'd7, OpImgTx = 4'd8, OpConv = 4'd9;
    localparam logic [3:0] OpSetPasses = 4'd10, OpGetStatus = 4'd11, OpClrErr = 4'd12;
    localparam logic [1:0] SelRx = 2'd1, SelTx = 2'd2, SelConv = 2'd3;
    localparam logic [WDOG_W-1:0] WdogMax = '1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                err_q, err_d;
    logic [DIM_W-1:0]    nrows_q, nrows_d, ncols_q, ncols_d;
    logic [SIGMA_W-1:0]  sigma_q, sigma_d;
    logic [PASS_W-1:0]   passes_q, passes_d, pass_cnt_q, pass_cnt_d;
    logic                rx_start_q, rx_start_d, tx_start_q, tx_start_d;
    logic                conv_start_q, conv_start_d, sub_abort_q, sub_abort_d;
    logic                swap_q, swap_d, buf_sel_q, buf_sel_d;
    logic [1:0]          img_sel_q, img_sel_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                sel_busy, dim_zero;

    // img_sel doubles as the record of which controller is being waited on
    always_comb begin
        case (img_sel_q)
            SelRx:   sel_busy = rx_busy;
            SelTx:   sel_busy = tx_busy;
            SelConv: sel_busy = conv_busy;
            default: sel_busy = 1'b0;
        endcase
    end

    assign dim_zero = (nrows_q == '0) || (ncols_q == '0);

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        err_d        = err_q;
        nrows_d      = nrows_q;
        ncols_d      = ncols_q;
        sigma_d      = sigma_q;
        passes_d     = passes_q;
        pass_cnt_d   = pass_cnt_q;
        rx_start_d   = 1'b0;
        tx_start_d   = 1'b0;
        conv_start_d = 1'b0;
        sub_abort_d  = 1'b0;
        swap_d       = swap_q;
        img_sel_d    = img_sel_q;
        buf_sel_d    = buf_sel_q;
        wdog_d       = wdog_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    case (op)
                        OpGetNrows: begin dout_d = DATA_W'(nrows_q); dout_valid_d = 1'b1; end
                        OpGetNcols: begin dout_d = DATA_W'(ncols_q); dout_valid_d = 1'b1; end
                        OpGetSigma: begin dout_d = DATA_W'(sigma_q); dout_valid_d = 1'b1; end
                        OpGetStatus: begin
                            dout_d       = DATA_W'({err_q, swap_q, passes_q});
                            dout_valid_d = 1'b1;
                        end
                        OpSetNrows: nrows_d = DIM_W'(din);
                        OpSetNcols: ncols_d = DIM_W'(din);
                        OpSetSigma: sigma_d = SIGMA_W'(din);
                        OpSetPasses: begin
                            if (PASS_W'(din) == '0) err_d = 1'b1;
                            else passes_d = PASS_W'(din);
                        end
                        OpClrErr: err_d = 1'b0;
                        OpImgRx, OpImgTx, OpConv: begin
                            if (dim_zero) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = StLaunch;
                                if (op == OpImgRx) begin
                                    img_sel_d  = SelRx;
                                    rx_start_d = 1'b1;
                                end else if (op == OpImgTx) begin
                                    img_sel_d  = SelTx;
                                    tx_start_d = 1'b1;
                                end else begin
                                    img_sel_d    = SelConv;
                                    buf_sel_d    = 1'b1;
                                    pass_cnt_d   = passes_q;
                                    conv_start_d = 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StLaunch: begin
                state_d = StWait;
                wdog_d  = '0;
            end
            StWait: begin
                if (!sel_busy) begin
                    if (img_sel_q == SelConv && pass_cnt_q > PASS_W'(1)) begin
                        pass_cnt_d = pass_cnt_q - PASS_W'(1);
                        swap_d     = ~swap_q;
                        state_d    = StGap;
                    end else begin
                        state_d   = StIdle;
                        img_sel_d = 2'd0;
                        buf_sel_d = 1'b0;
                    end
                end else if (wdog_q + WDOG_W'(1) == WdogMax) begin
                    err_d       = 1'b1;
                    sub_abort_d = 1'b1;
                    state_d     = StIdle;
                    img_sel_d   = 2'd0;
                    buf_sel_d   = 1'b0;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            StGap: begin
                state_d      = StLaunch;
                conv_start_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides whatever the state logic chose, including a same-cycle completion
        if (abort && state_q != StIdle) begin
            state_d      = StIdle;
            err_d        = err_q;
            swap_d       = swap_q;
            img_sel_d    = 2'd0;
            buf_sel_d    = 1'b0;
            conv_start_d = 1'b0;
            sub_abort_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
            nrows_q      <= DIM_W'(8);
            ncols_q      <= DIM_W'(8);
            sigma_q      <= '0;
            passes_q     <= PASS_W'(2);
            pass_cnt_q   <= '0;
            rx_start_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
            sub_abort_q  <= 1'b0;
            swap_q       <= 1'b0;
            img_sel_q    <= 2'd0;
            buf_sel_q    <= 1'b0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
            nrows_q      <= nrows_d;
            ncols_q      <= ncols_d;
            sigma_q      <= sigma_d;
            passes_q     <= passes_d;
            pass_cnt_q   <= pass_cnt_d;
            rx_start_q   <= rx_start_d;
            tx_start_q   <= tx_start_d;
            conv_start_q <= conv_start_d;
            sub_abort_q  <= sub_abort_d;
            swap_q       <= swap_d;
            img_sel_q    <= img_sel_d;
            buf_sel_q    <= buf_sel_d;
            wdog_q       <= wdog_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q != StIdle);
    assign err        = err_q;
    assign nrows      = nrows_q;
    assign ncols      = ncols_q;
    assign rx_start   = rx_start_q;
    assign tx_start   = tx_start_q;
    assign conv_start = conv_start_q;
    assign sub_abort  = sub_abort_q;
    assign conv_nrows = swap_q ? ncols_q : nrows_q;
    assign conv_ncols = swap_q ? nrows_q : ncols_q;
    assign conv_sigma = sigma_q;
    assign img_sel    = img_sel_q;
    assign buf_sel    = buf_sel_q;
    assign swap       = swap_q;
endmodule

// File: tb/tb_img_conv_seq.sv
// Directed bench for img_conv_seq: stub controllers with fixed busy lengths, plus a second
// instance with a 4-bit watchdog and a permanently busy convolution controller.
module tb_img_conv_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] din = 8'd0;
    logic       abort = 1'b0;

    logic [7:0] dout, nrows, ncols, conv_nrows, conv_ncols;
    logic       dout_valid, busy, err, rx_start, tx_start, conv_start, sub_abort, buf_sel, swap;
    logic [2:0] conv_sigma;
    logic [1:0] img_sel;
    logic       rx_busy, tx_busy, conv_busy;

    logic [7:0] w_dout, w_nrows, w_ncols, w_conv_nrows, w_conv_ncols;
    logic       w_dout_valid, w_busy, w_err, w_rx_start, w_tx_start, w_conv_start, w_sub_abort;
    logic       w_buf_sel, w_swap;
    logic [2:0] w_conv_sigma;
    logic [1:0] w_img_sel;

    int rx_cnt = 0, tx_cnt = 0, conv_cnt = 0;
    int rx_pulses = 0, conv_pulses = 0;
    int vectors = 0, miscompares = 0;
    int n, p0;

    always #5 clk = ~clk;

    img_conv_seq u_dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .abort(abort),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .err(err),
        .nrows(nrows), .ncols(ncols), .rx_start(rx_start), .tx_start(tx_start),
        .conv_start(conv_start), .rx_busy(rx_busy), .tx_busy(tx_busy), .conv_busy(conv_busy),
        .sub_abort(sub_abort), .conv_nrows(conv_nrows), .conv_ncols(conv_ncols),
        .conv_sigma(conv_sigma), .img_sel(img_sel), .buf_sel(buf_sel), .swap(swap)
    );

    img_conv_seq #(.WDOG_W(4)) u_wd (
        .clk(clk), .rst(rst), .en(en), .op(op), .din(din), .abort(abort),
        .dout(w_dout), .dout_valid(w_dout_valid), .busy(w_busy), .err(w_err),
        .nrows(w_nrows), .ncols(w_ncols), .rx_start(w_rx_start), .tx_start(w_tx_start),
        .conv_start(w_conv_start), .rx_busy(1'b0), .tx_busy(1'b0), .conv_busy(1'b1),
        .sub_abort(w_sub_abort), .conv_nrows(w_conv_nrows), .conv_ncols(w_conv_ncols),
        .conv_sigma(w_conv_sigma), .img_sel(w_img_sel), .buf_sel(w_buf_sel), .swap(w_swap)
    );

    // Stub controllers: busy for a fixed number of cycles after each start pulse
    always @(posedge clk) begin
        if (rx_start) begin rx_cnt <= 20; rx_pulses <= rx_pulses + 1; end
        else if (rx_cnt != 0) rx_cnt <= rx_cnt - 1;
        if (tx_start) tx_cnt <= 5;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
        if (conv_start) begin conv_cnt <= 3; conv_pulses <= conv_pulses + 1; end
        else if (conv_cnt != 0) conv_cnt <= conv_cnt - 1;
    end
    assign rx_busy   = (rx_cnt != 0);
    assign tx_busy   = (tx_cnt != 0);
    assign conv_busy = (conv_cnt != 0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] o, input logic [7:0] d);
        en = 1'b1; op = o; din = d;
        tick();
        en = 1'b0; op = 4'd0; din = 8'd0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #12 rst = 1'b0;
        tick();
        check("rst_nrows", nrows, 8);
        check("rst_ncols", ncols, 8);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_dout", dout, 0);
        check("rst_sel", {img_sel, buf_sel, swap}, 0);
        cmd(4'd11, 8'd0);
        check("rst_status", dout, 8'd2);

        cmd(4'd4, 8'd5);
        cmd(4'd1, 8'd0);
        check("get_nrows", dout, 5);
        check("get_valid", dout_valid, 1);
        check("get_busy", busy, 0);
        tick();
        check("valid_pulse", dout_valid, 0);
        check("dout_hold", dout, 5);
        cmd(4'd6, 8'hfd);
        check("sigma", conv_sigma, 5);
        cmd(4'd3, 8'd0);
        check("get_sigma", dout, 5);

        // RX: stub busy 20 cycles -> sequencer busy 22 cycles
        p0 = rx_pulses;
        cmd(4'd7, 8'd0);
        check("rx_start", rx_start, 1);
        check("rx_sel", img_sel, 1);
        n = 1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy) n++;
            else break;
        end
        check("rx_busy_len", n, 22);
        check("rx_pulses", rx_pulses - p0, 1);
        check("rx_sel_end", img_sel, 0);

        // Two-pass convolution
        cmd(4'd4, 8'd4);
        cmd(4'd5, 8'd6);
        cmd(4'd10, 8'd2);
        p0 = conv_pulses;
        cmd(4'd9, 8'd0);
        check("c1_start", conv_start, 1);
        check("c1_sel", {img_sel, buf_sel}, 3'b111);
        check("c1_dims", {conv_nrows, conv_ncols}, {8'd4, 8'd6});
        check("c1_swap", swap, 0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (conv_start) begin n = 1; break; end
        end
        check("c2_start_seen", n, 1);
        check("c2_swap", swap, 1);
        check("c2_dims", {conv_nrows, conv_ncols}, {8'd6, 8'd4});
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!busy) begin n = 1; break; end
        end
        check("conv_done", n, 1);
        check("conv_end_swap", swap, 1);
        check("conv_end_sel", {img_sel, buf_sel}, 0);
        check("conv_pulses", conv_pulses - p0, 2);
        cmd(4'd11, 8'd0);
        check("status_swap", dout, 8'd10);

        // Zero-dimension rejection and error clear
        cmd(4'd5, 8'd0);
        p0 = conv_pulses;
        cmd(4'd9, 8'd0);
        check("zd_err", err, 1);
        check("zd_busy", busy, 0);
        tick();
        check("zd_nostart", conv_pulses - p0, 0);
        cmd(4'd12, 8'd0);
        check("clr_err", err, 0);
        cmd(4'd10, 8'd0);
        cmd(4'd11, 8'd0);
        check("pass0_status", dout, 8'd26);
        cmd(4'd12, 8'd0);

        // Abort in TX WAIT on the same cycle tx_busy falls
        cmd(4'd5, 8'd6);
        cmd(4'd8, 8'd0);
        check("tx_sel", img_sel, 2);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_sub_abort", sub_abort, 1);
        check("ab_busy", busy, 0);
        check("ab_err", err, 0);
        check("ab_sel", img_sel, 0);
        tick();
        check("ab_pulse", sub_abort, 0);

        // Reset in the middle of a convolution
        cmd(4'd9, 8'd0);
        repeat (3) tick();
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rr_busy", busy, 0);
        check("rr_dims", {nrows, ncols}, {8'd8, 8'd8});
        check("rr_sel", {img_sel, buf_sel, swap}, 0);
        check("rr_sigma", conv_sigma, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        cmd(4'd11, 8'd0);
        check("rr_status", dout, 8'd2);

        // Watchdog instance: conv_busy stuck high, 4-bit counter
        cmd(4'd9, 8'd0);
        check("wd_busy", w_busy, 1);
        repeat (15) tick();
        check("wd_pre_err", w_err, 0);
        check("wd_pre_busy", w_busy, 1);
        tick();
        check("wd_err", w_err, 1);
        check("wd_sub_abort", w_sub_abort, 1);
        check("wd_idle", w_busy, 0);
        check("wd_sel", {w_img_sel, w_buf_sel}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
